// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types, geometry constants and PLRU/address helpers for
//               the 4-way cache miss/fill controller.
//               Geometry: SETS sets, word-granular 32-bit addresses laid out as
//               {tag[TAG_W], index[INDEX_W], offset[2]}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int SETS     = 16;
    localparam int WAYS     = 4;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FETCH     = 2'd2,
        ST_FILL      = 2'd3
    } ctrl_state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    // Tree PLRU, bits {b2,b1,b0}: b0 picks the half, b1/b2 pick within a half.
    function automatic logic [1:0] plru_victim(input logic [2:0] bits);
        if (bits[0]) begin
            return bits[2] ? 2'd3 : 2'd2;
        end
        return bits[1] ? 2'd1 : 2'd0;
    endfunction

    // Point the tree away from the way just accessed.
    function automatic logic [2:0] plru_update(input logic [2:0] bits,
                                              input logic [1:0] way);
        logic [2:0] nb;
        nb    = bits;
        nb[0] = ~way[1];
        if (!way[1]) begin
            nb[1] = ~way[0];
        end else begin
            nb[2] = ~way[0];
        end
        return nb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_miss_ctrl_plru4.sv
// ============================================================================
// Module      : plru4
// Description : Per-set 3-bit tree-PLRU storage for a 4-way cache.
//               Ports:
//                 CLK, RST          clock, async active-low reset (all bits 0)
//                 update_en         apply an access to update_index/update_way
//                 update_index/way  set and way being accessed
//                 read_index        set whose victim is reported
//                 victim            combinational PLRU victim of read_index
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru4
    import cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               update_en,
    input  logic [INDEX_W-1:0] update_index,
    input  logic [1:0]         update_way,
    input  logic [INDEX_W-1:0] read_index,
    output logic [1:0]         victim
);

    logic [2:0] r_bits [SETS];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < SETS; s++) begin
                r_bits[s] <= 3'b000;
            end
        end else if (update_en) begin
            r_bits[update_index] <= plru_update(r_bits[update_index], update_way);
        end
    end

    assign victim = plru_victim(r_bits[read_index]);

endmodule

`default_nettype wire

// File: rtl/cache_miss_ctrl.sv
// ============================================================================
// Module      : cache_miss_ctrl
// Description : Miss/fill controller beside a 4-way set-associative lookup
//               array. Keeps PLRU state, writes back dirty victims, fetches
//               the missing word and issues a one-cycle fill write. Stalls
//               the pipeline from the miss cycle until the replay hits.
//               Ports:
//                 CLK, RST                  clock, async active-low reset
//                 req_valid/we/addr/wdata   CPU access
//                 hit, hit_way              lookup result for req_addr
//                 way_valid/dirty/tag/data  contents of the indexed set
//                 stall                     hold the pipeline
//                 mem_rd_req/wr_req         level requests, held until mem_ack
//                 mem_addr/wdata            request address / writeback data
//                 mem_ack, mem_rdata        request completion / read data
//                 fill_en/way/index/tag/data/dirty  array write port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_miss_ctrl
    import cache_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic                 hit,
    input  logic [1:0]           hit_way,
    input  logic [WAYS-1:0]      way_valid,
    input  logic [WAYS-1:0]      way_dirty,
    input  logic [WAYS*TAG_W-1:0] way_tag,
    input  logic [WAYS*32-1:0]   way_data,
    output logic                 stall,
    output logic                 mem_rd_req,
    output logic                 mem_wr_req,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 fill_en,
    output logic [1:0]           fill_way,
    output logic [INDEX_W-1:0]   fill_index,
    output logic [TAG_W-1:0]     fill_tag,
    output logic [31:0]          fill_data,
    output logic                 fill_dirty
);

    ctrl_state_t        r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [1:0]         r_victim;
    logic [TAG_W-1:0]   r_vtag;
    logic [31:0]        r_vdata;
    logic [31:0]        r_rdata;

    logic [1:0]         w_plru_victim;
    logic [1:0]         w_victim;
    logic               w_found_invalid;
    logic [TAG_W-1:0]   w_vtag;
    logic [31:0]        w_vdata;
    logic               w_idle_active;
    logic               w_miss;
    logic               w_hit_access;
    logic               w_plru_en;
    logic [INDEX_W-1:0] w_plru_index;
    logic [1:0]         w_plru_way;
    logic               w_unused;

    // Offset bits never matter: the controller is word-granular.
    assign w_unused = ^req_addr[OFFSET_W-1:0];

    // Combinational outputs in IDLE depend on live inputs; gating them with
    // RST keeps every output at 0 while reset is held.
    assign w_idle_active = (r_state == ST_IDLE) && RST && req_valid;
    assign w_miss        = w_idle_active && !hit;
    assign w_hit_access  = w_idle_active && hit;

    // Victim: lowest-index invalid way, otherwise the PLRU choice.
    always_comb begin
        w_victim        = w_plru_victim;
        w_found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found_invalid && !way_valid[w]) begin
                w_victim        = 2'(w);
                w_found_invalid = 1'b1;
            end
        end
    end

    assign w_vtag  = way_tag[int'(w_victim)*TAG_W +: TAG_W];
    assign w_vdata = way_data[int'(w_victim)*32 +: 32];

    // Hits in IDLE and the fill of a victim are the only PLRU accesses; they
    // cannot coincide because they belong to different states.
    assign w_plru_en    = w_hit_access || (r_state == ST_FILL);
    assign w_plru_index = (r_state == ST_FILL) ? r_index  : addr_index(req_addr);
    assign w_plru_way   = (r_state == ST_FILL) ? r_victim : hit_way;

    plru4 u_plru (
        .CLK          (CLK),
        .RST          (RST),
        .update_en    (w_plru_en),
        .update_index (w_plru_index),
        .update_way   (w_plru_way),
        .read_index   (addr_index(req_addr)),
        .victim       (w_plru_victim)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_tag    <= '0;
            r_index  <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_victim <= '0;
            r_vtag   <= '0;
            r_vdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_tag    <= addr_tag(req_addr);
                        r_index  <= addr_index(req_addr);
                        r_we     <= req_we;
                        r_wdata  <= req_wdata;
                        r_victim <= w_victim;
                        r_vtag   <= w_vtag;
                        r_vdata  <= w_vdata;
                        r_state  <= (way_valid[w_victim] && way_dirty[w_victim])
                                    ? ST_WRITEBACK : ST_FETCH;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_rdata <= mem_rdata;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall      = w_miss || (r_state != ST_IDLE);
        mem_rd_req = (r_state == ST_FETCH);
        mem_wr_req = (r_state == ST_WRITEBACK);
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_en    = 1'b0;
        fill_way   = '0;
        fill_index = '0;
        fill_tag   = '0;
        fill_data  = '0;
        fill_dirty = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Store hit writes straight into the array without stalling.
                if (w_hit_access && req_we) begin
                    fill_en    = 1'b1;
                    fill_way   = hit_way;
                    fill_index = addr_index(req_addr);
                    fill_tag   = addr_tag(req_addr);
                    fill_data  = req_wdata;
                    fill_dirty = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                mem_addr  = {r_vtag, r_index, 2'b00};
                mem_wdata = r_vdata;
            end
            ST_FETCH: begin
                mem_addr = {r_tag, r_index, 2'b00};
            end
            ST_FILL: begin
                fill_en    = 1'b1;
                fill_way   = r_victim;
                fill_index = r_index;
                fill_tag   = r_tag;
                fill_data  = r_we ? r_wdata : r_rdata;
                fill_dirty = r_we;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
// ============================================================================
// Module      : tb_cache_miss_ctrl
// Description : Directed self-checking bench for cache_miss_ctrl. Inputs are
//               driven just after each falling edge and outputs are checked
//               1 ns later, half a period away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_miss_ctrl;
    import cache_pkg::*;

    logic                  CLK;
    logic                  RST;
    logic                  req_valid;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  hit;
    logic [1:0]            hit_way;
    logic [3:0]            way_valid;
    logic [3:0]            way_dirty;
    logic [4*TAG_W-1:0]    way_tag;
    logic [127:0]          way_data;
    logic                  stall;
    logic                  mem_rd_req;
    logic                  mem_wr_req;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;
    logic                  fill_en;
    logic [1:0]            fill_way;
    logic [INDEX_W-1:0]    fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic [31:0]           fill_data;
    logic                  fill_dirty;

    int n_vec = 0;
    int n_err = 0;

    cache_miss_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .hit        (hit),
        .hit_way    (hit_way),
        .way_valid  (way_valid),
        .way_dirty  (way_dirty),
        .way_tag    (way_tag),
        .way_data   (way_data),
        .stall      (stall),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_en    (fill_en),
        .fill_way   (fill_way),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .fill_dirty (fill_dirty)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic miss_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] vv, input logic [3:0] dd);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        hit       = 1'b0;
        hit_way   = 2'd0;
        way_valid = vv;
        way_dirty = dd;
    endtask

    task automatic hit_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input logic [1:0] w);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        hit       = 1'b1;
        hit_way   = w;
        way_valid = 4'hF;
    endtask

    task automatic chk_fill(input string tag, input logic [1:0] w, input logic [31:0] idx,
                            input logic [31:0] tg, input logic [31:0] d, input logic dirty);
        chk({tag, "_en"},    32'(fill_en),    32'd1);
        chk({tag, "_way"},   32'(fill_way),   32'(w));
        chk({tag, "_index"}, 32'(fill_index), idx);
        chk({tag, "_tag"},   32'(fill_tag),   tg);
        chk({tag, "_data"},  fill_data,       d);
        chk({tag, "_dirty"}, 32'(fill_dirty), 32'(dirty));
        chk({tag, "_stall"}, 32'(stall),      32'd1);
    endtask

    // Replayed lookup hits in the cycle after FILL: no stall, no write.
    task automatic replay(input string tag, input logic [31:0] a, input logic [1:0] w);
        @(negedge CLK);
        hit_req(a, 1'b0, 32'd0, w);
        #1;
        chk({tag, "_replay_stall"}, 32'(stall),   32'd0);
        chk({tag, "_replay_fill"},  32'(fill_en), 32'd0);
        @(negedge CLK);
        req_valid = 1'b0;
        hit       = 1'b0;
    endtask

    initial begin
        RST       = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0040;
        req_wdata = 32'd0;
        hit       = 1'b0;
        hit_way   = 2'd0;
        way_valid = 4'h0;
        way_dirty = 4'h0;
        way_tag   = '0;
        way_data  = '0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;

        // Reset state: every output 0 even with a missing request presented.
        #2;
        chk("rst_stall",  32'(stall),      32'd0);
        chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("rst_wr_req", 32'(mem_wr_req), 32'd0);
        chk("rst_fill",   32'(fill_en),    32'd0);
        chk("rst_addr",   mem_addr,        32'd0);
        @(negedge CLK);
        RST       = 1'b1;
        req_valid = 1'b0;

        // 1: reset in the middle of FETCH.
        @(negedge CLK);
        miss_req(32'h0000_0040, 1'b0, 32'd0, 4'h0, 4'h0);
        #1 chk("t1_miss_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        #1 chk("t1_rd_req", 32'(mem_rd_req), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("t1_rst_rd_req", 32'(mem_rd_req), 32'd0);
        chk("t1_rst_stall",  32'(stall),      32'd0);
        @(negedge CLK);
        RST       = 1'b1;
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_late_ack_rd", 32'(mem_rd_req), 32'd0);
        chk("t1_late_ack_st", 32'(stall),      32'd0);
        @(negedge CLK);
        mem_ack = 1'b0;
        #1 chk("t1_no_fill", 32'(fill_en), 32'd0);

        // 2: cold load of 0x40 -> tag 1, index 0, way 0.
        @(negedge CLK);
        miss_req(32'h0000_0040, 1'b0, 32'd0, 4'h0, 4'h0);
        #1 chk("t2_stall_same_cycle", 32'(stall), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("t2_rd_req", 32'(mem_rd_req), 32'd1);
        chk("t2_addr",   mem_addr,        32'h0000_0040);
        @(negedge CLK);
        mem_ack = 1'b0;
        #1 chk_fill("t2_fill", 2'd0, 32'd0, 32'd1, 32'hCAFE_F00D, 1'b0);
        replay("t2", 32'h0000_0040, 2'd0);      // set0 PLRU {b2,b1,b0}=011

        // 3: store hit to way 2 at 0x80 (tag 2, index 0); set0 PLRU -> 110.
        hit_req(32'h0000_0080, 1'b1, 32'h0000_1234, 2'd2);
        #1;
        chk("t3_stall", 32'(stall), 32'd0);
        chk("t3_fill_en", 32'(fill_en), 32'd1);
        chk("t3_way", 32'(fill_way), 32'd2);
        chk("t3_dirty", 32'(fill_dirty), 32'd1);
        chk("t3_data", fill_data, 32'h0000_1234);
        chk("t3_tag", 32'(fill_tag), 32'd2);
        @(negedge CLK);
        req_valid = 1'b0;
        hit       = 1'b0;

        // 4: set0 full, PLRU 110 -> victim way1, dirty (tag 5, data AAAA).
        @(negedge CLK);
        miss_req(32'h0000_01C0, 1'b0, 32'd0, 4'hF, 4'b0010);
        way_tag  = {26'h13, 26'h12, 26'h5, 26'h10};
        way_data = {32'h3333, 32'h2222, 32'hAAAA, 32'h1111};
        #1 chk("t4_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        way_tag   = '1;
        way_data  = '1;
        #1;
        chk("t4_wr_req", 32'(mem_wr_req), 32'd1);
        chk("t4_rd_req_off", 32'(mem_rd_req), 32'd0);
        chk("t4_wb_addr", mem_addr, 32'h0000_0140);
        chk("t4_wb_data", mem_wdata, 32'h0000_AAAA);
        @(negedge CLK);
        mem_ack = 1'b1;
        #1 chk("t4_wr_held", 32'(mem_wr_req), 32'd1);
        @(negedge CLK);
        mem_ack = 1'b0;
        #1;
        chk("t4_fetch_rd", 32'(mem_rd_req), 32'd1);
        chk("t4_fetch_wr_off", 32'(mem_wr_req), 32'd0);
        chk("t4_fetch_addr", mem_addr, 32'h0000_01C0);
        @(negedge CLK);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_5555;
        @(negedge CLK);
        mem_ack = 1'b0;
        #1 chk_fill("t4_fill", 2'd1, 32'd0, 32'd7, 32'h0000_5555, 1'b0);
        replay("t4", 32'h0000_01C0, 2'd1);      // set0 PLRU -> 101

        // 4b: b2 set by the store hit shows up as victim way3.
        miss_req(32'h0000_0200, 1'b0, 32'd0, 4'hF, 4'h0);
        @(negedge CLK);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0B0B;
        #1 chk("t4b_fetch_addr", mem_addr, 32'h0000_0200);
        @(negedge CLK);
        mem_ack = 1'b0;
        #1 chk_fill("t4b_fill", 2'd3, 32'd0, 32'd8, 32'h0000_0B0B, 1'b0);
        replay("t4b", 32'h0000_0200, 2'd3);

        // 5: PLRU order in set3; hits on 0,1,2,3 leave PLRU 000.
        for (int w = 0; w < 4; w++) begin
            hit_req(32'h0000_040C, 1'b0, 32'd0, 2'(w));
            #1 chk("t5_hit_stall", 32'(stall), 32'd0);
            @(negedge CLK);
        end
        miss_req(32'h0000_080C, 1'b0, 32'd0, 4'hF, 4'h0);
        @(negedge CLK);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0C0C;
        @(negedge CLK);
        mem_ack = 1'b0;
        #1 chk_fill("t5_fill1", 2'd0, 32'd3, 32'h20, 32'h0000_0C0C, 1'b0);
        replay("t5a", 32'h0000_080C, 2'd0);     // access way0 -> PLRU 011
        miss_req(32'h0000_084C, 1'b0, 32'd0, 4'hF, 4'h0);
        @(negedge CLK);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0D0D;
        @(negedge CLK);
        mem_ack = 1'b0;
        #1 chk_fill("t5_fill2", 2'd2, 32'd3, 32'h21, 32'h0000_0D0D, 1'b0);
        replay("t5b", 32'h0000_084C, 2'd2);

        // 6: slow memory store miss, offset bits set, req_* scrambled meanwhile.
        miss_req(32'h0000_0CD7, 1'b1, 32'h0000_BEEF, 4'h0, 4'h0);
        @(negedge CLK);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_we    = i[0];
            req_addr  = 32'hFFFF_FFF0 ^ 32'(i);
            req_wdata = 32'h1111_0000 + 32'(i);
            hit       = i[1];
            #1;
            chk("t6_stall_held", 32'(stall), 32'd1);
            chk("t6_addr_held", mem_addr, 32'h0000_0CD4);
            @(negedge CLK);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_7777;
        @(negedge CLK);
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        #1 chk_fill("t6_fill", 2'd0, 32'd5, 32'h33, 32'h0000_BEEF, 1'b1);
        replay("t6", 32'h0000_0CD4, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
